// File: rtl/plt_collision_sched.sv
// Per-frame sweep scheduler: shares one platform-collision checker across both
// players and all platforms, publishing a grounded flag and the landed platform per player.
module plt_collision_sched #(
    parameter int NUM_PLT = 3,
    parameter int PLT_W   = $clog2(NUM_PLT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic signed [10:0]      p0_x,
    input  logic signed [10:0]      p0_y,
    input  logic signed [10:0]      p0_next_y,
    input  logic signed [10:0]      p1_x,
    input  logic signed [10:0]      p1_y,
    input  logic signed [10:0]      p1_next_y,
    output logic signed [10:0]      chk_x,
    output logic signed [10:0]      chk_y,
    output logic signed [10:0]      chk_next_y,
    output logic [PLT_W-1:0]        chk_plt,
    output logic                    chk_valid,
    input  logic                    chk_hit,
    output logic                    busy,
    output logic                    done,
    output logic                    p0_grounded,
    output logic [PLT_W-1:0]        p0_plt,
    output logic                    p1_grounded,
    output logic [PLT_W-1:0]        p1_plt
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;

    localparam logic [PLT_W-1:0] LAST_PLT = PLT_W'(NUM_PLT - 1);
    localparam logic [PLT_W-1:0] PLT_ZERO = {PLT_W{1'b0}};
    localparam logic [PLT_W-1:0] PLT_ONE  = PLT_W'(1);

    state_t                  state_q, state_d;
    logic signed [10:0]      s0_x_q, s0_y_q, s0_ny_q, s1_x_q, s1_y_q, s1_ny_q;
    logic signed [10:0]      s0_x_d, s0_y_d, s0_ny_d, s1_x_d, s1_y_d, s1_ny_d;
    logic signed [10:0]      chk_x_q, chk_y_q, chk_ny_q, chk_x_d, chk_y_d, chk_ny_d;
    logic [PLT_W-1:0]        chk_plt_q, chk_plt_d;
    logic                    player_q, player_d;
    logic                    g0_acc_q, g0_acc_d, g1_acc_q, g1_acc_d;
    logic [PLT_W-1:0]        i0_acc_q, i0_acc_d, i1_acc_q, i1_acc_d;
    logic                    p0_g_q, p0_g_d, p1_g_q, p1_g_d;
    logic [PLT_W-1:0]        p0_p_q, p0_p_d, p1_p_q, p1_p_d;
    logic                    busy_q, busy_d, valid_q, valid_d, done_q, done_d;

    // Next-state, snapshot, checker drive and hit accumulation.
    always_comb begin
        state_d   = state_q;
        s0_x_d    = s0_x_q;
        s0_y_d    = s0_y_q;
        s0_ny_d   = s0_ny_q;
        s1_x_d    = s1_x_q;
        s1_y_d    = s1_y_q;
        s1_ny_d   = s1_ny_q;
        chk_x_d   = chk_x_q;
        chk_y_d   = chk_y_q;
        chk_ny_d  = chk_ny_q;
        chk_plt_d = chk_plt_q;
        player_d  = player_q;
        g0_acc_d  = g0_acc_q;
        i0_acc_d  = i0_acc_q;
        g1_acc_d  = g1_acc_q;
        i1_acc_d  = i1_acc_q;
        p0_g_d    = p0_g_q;
        p0_p_d    = p0_p_q;
        p1_g_d    = p1_g_q;
        p1_p_d    = p1_p_q;
        case (state_q)
            IDLE, DONE: begin
                if (frame_start) begin
                    // Pair 0 is loaded straight from the ports, the same edge the snapshot is taken.
                    s0_x_d    = p0_x;
                    s0_y_d    = p0_y;
                    s0_ny_d   = p0_next_y;
                    s1_x_d    = p1_x;
                    s1_y_d    = p1_y;
                    s1_ny_d   = p1_next_y;
                    chk_x_d   = p0_x;
                    chk_y_d   = p0_y;
                    chk_ny_d  = p0_next_y;
                    chk_plt_d = PLT_ZERO;
                    player_d  = 1'b0;
                    g0_acc_d  = 1'b0;
                    i0_acc_d  = PLT_ZERO;
                    g1_acc_d  = 1'b0;
                    i1_acc_d  = PLT_ZERO;
                    state_d   = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                // Only the first hit records its index, so the lowest platform wins.
                if (chk_hit && !player_q) begin
                    g0_acc_d = 1'b1;
                    i0_acc_d = g0_acc_q ? i0_acc_q : chk_plt_q;
                end else if (chk_hit && player_q) begin
                    g1_acc_d = 1'b1;
                    i1_acc_d = g1_acc_q ? i1_acc_q : chk_plt_q;
                end else begin
                    g0_acc_d = g0_acc_q;
                    g1_acc_d = g1_acc_q;
                end
                if (chk_plt_q != LAST_PLT) begin
                    chk_plt_d = chk_plt_q + PLT_ONE;
                    chk_x_d   = player_q ? s1_x_q  : s0_x_q;
                    chk_y_d   = player_q ? s1_y_q  : s0_y_q;
                    chk_ny_d  = player_q ? s1_ny_q : s0_ny_q;
                    state_d   = ISSUE;
                end else if (!player_q) begin
                    player_d  = 1'b1;
                    chk_plt_d = PLT_ZERO;
                    chk_x_d   = s1_x_q;
                    chk_y_d   = s1_y_q;
                    chk_ny_d  = s1_ny_q;
                    state_d   = ISSUE;
                end else begin
                    p0_g_d  = g0_acc_d;
                    p0_p_d  = i0_acc_d;
                    p1_g_d  = g1_acc_d;
                    p1_p_d  = i1_acc_d;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d == ISSUE) || (state_d == SAMPLE);
        valid_d = busy_d;
        done_d  = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s0_x_q    <= 11'sd0;
            s0_y_q    <= 11'sd0;
            s0_ny_q   <= 11'sd0;
            s1_x_q    <= 11'sd0;
            s1_y_q    <= 11'sd0;
            s1_ny_q   <= 11'sd0;
            chk_x_q   <= 11'sd0;
            chk_y_q   <= 11'sd0;
            chk_ny_q  <= 11'sd0;
            chk_plt_q <= PLT_ZERO;
            player_q  <= 1'b0;
            g0_acc_q  <= 1'b0;
            i0_acc_q  <= PLT_ZERO;
            g1_acc_q  <= 1'b0;
            i1_acc_q  <= PLT_ZERO;
            p0_g_q    <= 1'b0;
            p0_p_q    <= PLT_ZERO;
            p1_g_q    <= 1'b0;
            p1_p_q    <= PLT_ZERO;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s0_x_q    <= s0_x_d;
            s0_y_q    <= s0_y_d;
            s0_ny_q   <= s0_ny_d;
            s1_x_q    <= s1_x_d;
            s1_y_q    <= s1_y_d;
            s1_ny_q   <= s1_ny_d;
            chk_x_q   <= chk_x_d;
            chk_y_q   <= chk_y_d;
            chk_ny_q  <= chk_ny_d;
            chk_plt_q <= chk_plt_d;
            player_q  <= player_d;
            g0_acc_q  <= g0_acc_d;
            i0_acc_q  <= i0_acc_d;
            g1_acc_q  <= g1_acc_d;
            i1_acc_q  <= i1_acc_d;
            p0_g_q    <= p0_g_d;
            p0_p_q    <= p0_p_d;
            p1_g_q    <= p1_g_d;
            p1_p_q    <= p1_p_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign chk_x       = chk_x_q;
    assign chk_y       = chk_y_q;
    assign chk_next_y  = chk_ny_q;
    assign chk_plt     = chk_plt_q;
    assign chk_valid   = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign p0_grounded = p0_g_q;
    assign p0_plt      = p0_p_q;
    assign p1_grounded = p1_g_q;
    assign p1_plt      = p1_p_q;

endmodule

// File: tb/tb_plt_collision_sched.sv
// Self-checking bench for plt_collision_sched: a stand-in checker drives chk_hit and a
// per-player "first landing platform" model predicts the published results.
module tb_plt_collision_sched;

    localparam int N      = 3;
    localparam int PW     = 2;
    localparam int HEIGHT = 30;
    localparam int MAXC   = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic signed [10:0] p0_x = 11'sd0, p0_y = 11'sd0, p0_next_y = 11'sd0;
    logic signed [10:0] p1_x = 11'sd0, p1_y = 11'sd0, p1_next_y = 11'sd0;
    logic signed [10:0] chk_x, chk_y, chk_next_y;
    logic [PW-1:0] chk_plt, p0_plt, p1_plt;
    logic chk_valid, chk_hit, busy, done, p0_grounded, p1_grounded;

    plt_collision_sched #(.NUM_PLT(N)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .p0_x(p0_x), .p0_y(p0_y), .p0_next_y(p0_next_y),
        .p1_x(p1_x), .p1_y(p1_y), .p1_next_y(p1_next_y),
        .chk_x(chk_x), .chk_y(chk_y), .chk_next_y(chk_next_y), .chk_plt(chk_plt),
        .chk_valid(chk_valid), .chk_hit(chk_hit), .busy(busy), .done(done),
        .p0_grounded(p0_grounded), .p0_plt(p0_plt),
        .p1_grounded(p1_grounded), .p1_plt(p1_plt)
    );

    always #5 clk = ~clk;

    int plt_x [N] = '{600, 200, 420};
    int plt_w [N] = '{100, 150, 105};
    int plt_y [N] = '{300, 250, 215};

    logic               force_en = 1'b0;
    logic signed [10:0] fx0 = 11'sd0, fx1 = 11'sd0;
    logic [N-1:0]       fm0 = '0, fm1 = '0;

    int n_cmp = 0;
    int n_fail = 0;

    logic signed [10:0] s0x, s0y, s0n, s1x, s1y, s1n;
    logic signed [10:0] a0x, a0y, a0n, a1x, a1y, a1n;

    logic               ov [MAXC], ob [MAXC], od [MAXC], og0 [MAXC], og1 [MAXC];
    logic [PW-1:0]      op [MAXC], oi0 [MAXC], oi1 [MAXC];
    logic signed [10:0] ox [MAXC], oy [MAXC], ony [MAXC];

    function automatic logic env_hit(input logic signed [10:0] x, input logic signed [10:0] y,
                                     input logic signed [10:0] ny, input int p);
        if (force_en)
            return (x == fx0 && fm0[p]) || (x == fx1 && fm1[p]);
        return (int'(x) >= plt_x[p]) && (int'(x) < plt_x[p] + plt_w[p]) &&
               (int'(y) <= plt_y[p]) && (int'(ny) >= plt_y[p] - 2 * HEIGHT);
    endfunction

    always_comb chk_hit = env_hit(chk_x, chk_y, chk_next_y, int'(chk_plt));

    task automatic ref_land(input logic signed [10:0] x, input logic signed [10:0] y,
                            input logic signed [10:0] ny, output logic g, output logic [PW-1:0] idx);
        g = 1'b0;
        idx = '0;
        for (int p = 0; p < N; p++) begin
            if (!g && env_hit(x, y, ny, p)) begin
                g = 1'b1;
                idx = PW'(p);
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int x0, input int y0, input int n0, input int x1, input int y1, input int n1);
        s0x = 11'(x0); s0y = 11'(y0); s0n = 11'(n0);
        s1x = 11'(x1); s1y = 11'(y1); s1n = 11'(n1);
        p0_x = s0x; p0_y = s0y; p0_next_y = s0n;
        p1_x = s1x; p1_y = s1y; p1_next_y = s1n;
    endtask

    task automatic set_alt(input int x0, input int y0, input int n0, input int x1, input int y1, input int n1);
        a0x = 11'(x0); a0y = 11'(y0); a0n = 11'(n0);
        a1x = 11'(x1); a1y = 11'(y1); a1n = 11'(n1);
    endtask

    // Cycle 0 is the current cycle; records what the DUT shows in cycles 1..ncyc.
    task automatic run(input int ncyc, input int fs2, input int chg, input int rc);
        frame_start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            tick;
            ov[c] = chk_valid; ob[c] = busy; od[c] = done;
            ox[c] = chk_x; oy[c] = chk_y; ony[c] = chk_next_y; op[c] = chk_plt;
            og0[c] = p0_grounded; oi0[c] = p0_plt; og1[c] = p1_grounded; oi1[c] = p1_plt;
            frame_start = (c == fs2);
            rst = (c == rc);
            if (c == chg) begin
                p0_x = a0x; p0_y = a0y; p0_next_y = a0n;
                p1_x = a1x; p1_y = a1y; p1_next_y = a1n;
            end
        end
        frame_start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        int hits;
        set_pos(450, 150, 160, 100, 150, 160);
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        n_cmp++;
        if ({chk_x, chk_y, chk_next_y, chk_plt, chk_valid, busy, done, p0_grounded, p0_plt,
             p1_grounded, p1_plt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs not all zero (valid=%b busy=%b done=%b chk_x=%0d)",
                     chk_valid, busy, done, chk_x);
        end
        hits = 0;
        repeat (20) begin
            tick;
            if (chk_valid || busy || done || p0_grounded || p1_grounded) hits++;
        end
        n_cmp++;
        if (hits !== 0) begin
            n_fail++;
            $display("FAIL idle_quiet: %0d active cycles, required 0", hits);
        end
    endtask

    task automatic test_geometric;
        force_en = 1'b0;
        set_pos(450, 150, 160, 100, 150, 160);
        run(14, -1, -1, -1);
        for (int c = 1; c <= 14; c++) begin
            int k, pl, pi;
            k = (c - 1) / 2; pl = k / N; pi = k % N;
            n_cmp++;
            if (ov[c] !== (c <= 4 * N)) begin
                n_fail++;
                $display("FAIL geo_valid c%0d: got %b required %b", c, ov[c], (c <= 4 * N));
            end
            n_cmp++;
            if (od[c] !== (c == 4 * N + 1)) begin
                n_fail++;
                $display("FAIL geo_done c%0d: got %b required %b", c, od[c], (c == 4 * N + 1));
            end
            if (c <= 4 * N) begin
                n_cmp++;
                if (ox[c] !== (pl != 0 ? s1x : s0x) || op[c] !== PW'(pi)) begin
                    n_fail++;
                    $display("FAIL geo_pair c%0d: got x=%0d plt=%0d required x=%0d plt=%0d",
                             c, ox[c], op[c], (pl != 0 ? s1x : s0x), pi);
                end
            end
        end
        n_cmp++;
        if ({og0[12], og1[12]} !== 2'b00) begin
            n_fail++;
            $display("FAIL geo_early: results changed before done (%b%b)", og0[12], og1[12]);
        end
        n_cmp++;
        if ({og0[13], oi0[13], og1[13], oi1[13]} !== {1'b1, 2'd2, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL geo_result: got p0=%b/%0d p1=%b/%0d required p0=1/2 p1=0/0",
                     og0[13], oi0[13], og1[13], oi1[13]);
        end
    endtask

    task automatic test_priority;
        force_en = 1'b1;
        fx0 = 11'sd450; fm0 = 3'b000;
        fx1 = 11'sd100; fm1 = 3'b110;
        set_pos(450, 150, 160, 100, 150, 160);
        run(14, -1, -1, -1);
        n_cmp++;
        if ({og0[13], oi0[13], og1[13], oi1[13]} !== {1'b0, 2'd0, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL priority: got p0=%b/%0d p1=%b/%0d required p0=0/0 p1=1/1",
                     og0[13], oi0[13], og1[13], oi1[13]);
        end
        force_en = 1'b0;
    endtask

    task automatic test_midsweep;
        int dones, err;
        set_pos(450, 150, 160, 100, 150, 160);
        set_alt(100, 150, 160, 450, 150, 160);
        run(20, 7, 5, -1);
        dones = 0; err = 0;
        for (int c = 1; c <= 20; c++) if (od[c]) dones++;
        for (int c = 1; c <= 4 * N; c++) begin
            int k, pl;
            k = (c - 1) / 2; pl = k / N;
            if (ox[c] !== (pl != 0 ? s1x : s0x) || oy[c] !== (pl != 0 ? s1y : s0y) ||
                ony[c] !== (pl != 0 ? s1n : s0n) || op[c] !== PW'(k % N)) err++;
        end
        n_cmp++;
        if (err !== 0) begin
            n_fail++;
            $display("FAIL mid_snapshot: %0d cycles deviate from cycle-0 snapshot, required 0", err);
        end
        n_cmp++;
        if (dones !== 1 || od[13] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_done: got %0d pulses (c13=%b) required 1 at c13", dones, od[13]);
        end
        n_cmp++;
        if (ob[14] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ignored: busy=%b at c14, required 0", ob[14]);
        end
        n_cmp++;
        if ({og0[13], oi0[13], og1[13]} !== {1'b1, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_result: got p0=%b/%0d p1=%b required p0=1/2 p1=0", og0[13], oi0[13], og1[13]);
        end
    endtask

    task automatic test_back_to_back;
        set_pos(450, 150, 160, 100, 150, 160);
        set_alt(100, 150, 160, 450, 150, 160);
        run(27, 13, 10, -1);
        for (int c = 1; c <= 27; c++) begin
            n_cmp++;
            if (od[c] !== (c == 13 || c == 26)) begin
                n_fail++;
                $display("FAIL b2b_done c%0d: got %b required %b", c, od[c], (c == 13 || c == 26));
            end
        end
        n_cmp++;
        if (ob[14] !== 1'b1 || ox[14] !== a0x) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b x=%0d at c14, required busy=1 x=%0d", ob[14], ox[14], a0x);
        end
        n_cmp++;
        if ({og0[13], oi0[13], og1[13], oi1[13]} !== {1'b1, 2'd2, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL b2b_first: got p0=%b/%0d p1=%b/%0d required 1/2 0/0", og0[13], oi0[13], og1[13], oi1[13]);
        end
        n_cmp++;
        if ({og0[25], og0[26], oi0[26], og1[26], oi1[26]} !== {1'b1, 1'b0, 2'd0, 1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL b2b_second: got c25 p0=%b c26 p0=%b/%0d p1=%b/%0d required 1, 0/0 1/2",
                     og0[25], og0[26], oi0[26], og1[26], oi1[26]);
        end
    endtask

    task automatic test_reset_midsweep;
        int dones;
        logic g0, g1;
        logic [PW-1:0] i0, i1;
        set_pos(450, 150, 160, 100, 150, 160);
        run(14, -1, -1, 6);
        dones = 0;
        for (int c = 1; c <= 14; c++) if (od[c]) dones++;
        n_cmp++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL rst_nodone: got %0d done pulses, required 0", dones);
        end
        n_cmp++;
        if ({ox[7], oy[7], ony[7], op[7], ov[7], ob[7], od[7], og0[7], oi0[7], og1[7], oi1[7]} !== '0) begin
            n_fail++;
            $display("FAIL rst_clear: c7 valid=%b busy=%b p1=%b/%0d x=%0d, required all 0",
                     ov[7], ob[7], og1[7], oi1[7], ox[7]);
        end
        ref_land(s0x, s0y, s0n, g0, i0);
        ref_land(s1x, s1y, s1n, g1, i1);
        run(14, -1, -1, -1);
        n_cmp++;
        if (od[13] !== 1'b1 || {og0[13], oi0[13], og1[13], oi1[13]} !== {g0, i0, g1, i1}) begin
            n_fail++;
            $display("FAIL rst_fresh: done=%b p0=%b/%0d p1=%b/%0d required done=1 p0=%b/%0d p1=%b/%0d",
                     od[13], og0[13], oi0[13], og1[13], oi1[13], g0, i0, g1, i1);
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            int err, chg, x0, x1;
            logic g0, g1;
            logic [PW-1:0] i0, i1;
            force_en = 1'($urandom_range(0, 1));
            x0 = int'($urandom_range(0, 850)) - 100;
            x1 = int'($urandom_range(0, 850)) - 100;
            if (x1 == x0) x1 = x0 + 1;
            fx0 = 11'(x0); fx1 = 11'(x1);
            fm0 = N'($urandom); fm1 = N'($urandom);
            set_pos(x0, int'($urandom_range(100, 320)), int'($urandom_range(100, 360)),
                    x1, int'($urandom_range(100, 320)), int'($urandom_range(100, 360)));
            set_alt(int'($urandom_range(0, 700)), int'($urandom_range(100, 320)), int'($urandom_range(100, 360)),
                    int'($urandom_range(0, 700)), int'($urandom_range(100, 320)), int'($urandom_range(100, 360)));
            chg = int'($urandom_range(1, 12));
            ref_land(s0x, s0y, s0n, g0, i0);
            ref_land(s1x, s1y, s1n, g1, i1);
            run(14, -1, chg, -1);
            err = 0;
            for (int c = 1; c <= 4 * N; c++) begin
                int k, pl;
                k = (c - 1) / 2; pl = k / N;
                if (ov[c] !== 1'b1 || ox[c] !== (pl != 0 ? s1x : s0x) || oy[c] !== (pl != 0 ? s1y : s0y) ||
                    ony[c] !== (pl != 0 ? s1n : s0n) || op[c] !== PW'(k % N)) err++;
            end
            n_cmp++;
            if (err !== 0) begin
                n_fail++;
                $display("FAIL rnd%0d_pairs: %0d bad cycles, required 0", t, err);
            end
            n_cmp++;
            if (od[13] !== 1'b1 || {og0[13], oi0[13], og1[13], oi1[13]} !== {g0, i0, g1, i1}) begin
                n_fail++;
                $display("FAIL rnd%0d_result: done=%b p0=%b/%0d p1=%b/%0d required done=1 p0=%b/%0d p1=%b/%0d",
                         t, od[13], og0[13], oi0[13], og1[13], oi1[13], g0, i0, g1, i1);
            end
        end
        force_en = 1'b0;
    endtask

    initial begin
        test_reset;
        test_geometric;
        test_priority;
        test_midsweep;
        test_back_to_back;
        test_reset_midsweep;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
